// File: rtl/ipv_serializer_pkg.sv
// Shared IPV link definitions used by the serializer and the reducer.
// No logic: constants, the vote-vector type and width helpers only.
// Both link ends import this so the frame width always matches.
package ipv_pkg;

  localparam int IPV_K  = 4;
  localparam int VOTE_W = IPV_K;

  typedef logic [VOTE_W-1:0] vote_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Index width that never collapses to zero bits (DEPTH = 1 still needs a pointer).
  function automatic int idx_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ipv_serializer_fifo.sv
// Synchronous FIFO, DEPTH x W, oldest entry presented on dout.
// Latency: a push is visible on dout the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; full/empty are registered-state only.
module ipv_fifo
  import ipv_pkg::*;
#(
  parameter int W     = VOTE_W,
  parameter int DEPTH = 2,
  localparam int PW   = idx_w(DEPTH),
  localparam int LW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ipv_serializer.sv
// Serial IPV transmitter: K-bit vectors shifted out LSB first in K-cycle frames tied to a free-running counter.
// Latency: 1..K cycles from push into an empty FIFO to bit 0 on the wire (next frame boundary, no bypass).
// Backpressure: vin_ready low while the FIFO holds DEPTH entries; idle frames send zeros with frame_valid low.
module ipv_serializer
  import ipv_pkg::*;
#(
  parameter int K     = VOTE_W,
  parameter int DEPTH = 2,
  localparam int CW   = clog2(K),
  localparam int LW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [K-1:0]  vin,
  input  logic          vin_valid,
  output logic          vin_ready,
  output logic          ipv_out,
  output logic          ipv_sof,
  output logic          frame_valid,
  output logic [LW-1:0] fifo_level
);

  logic [CW-1:0] bit_cnt;
  logic [K-1:0]  shreg;
  logic [K-1:0]  head;
  logic          boundary;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;

  assign boundary  = (bit_cnt == CW'(K - 1));
  assign vin_ready = ~fifo_full;
  assign push      = vin_valid & vin_ready;
  assign pop       = boundary & ~fifo_empty;
  assign ipv_sof   = (bit_cnt == '0);
  assign ipv_out   = shreg[0];

  ipv_fifo #(
    .W     (K),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (vin),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame timing and shifter: load the FIFO head (or zeros) at each boundary, shift otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_valid <= 1'b0;
    end else begin
      bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
      if (boundary) begin
        if (!fifo_empty) begin
          shreg       <= head;
          frame_valid <= 1'b1;
        end else begin
          shreg       <= '0;
          frame_valid <= 1'b0;
        end
      end else begin
        shreg <= shreg >> 1;
      end
    end
  end

endmodule

// File: tb/tb_ipv_serializer.sv
// Directed cycle table plus randomized loopback through a behavioural reducer.
// K = 4, DEPTH = 2; inputs driven on the falling edge, outputs sampled on the falling edge.
// Summary line reports passed/total checks.
module tb_ipv_serializer;

  localparam int K     = 4;
  localparam int DEPTH = 2;
  localparam int NRAND = 200;

  logic       clk;
  logic       rst;
  logic [3:0] vin;
  logic       vin_valid;
  logic       vin_ready;
  logic       ipv_out;
  logic       ipv_sof;
  logic       frame_valid;
  logic [1:0] fifo_level;

  int checks = 0;
  int passes = 0;

  ipv_serializer #(.K(K), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .vin         (vin),
    .vin_valid   (vin_valid),
    .vin_ready   (vin_ready),
    .ipv_out     (ipv_out),
    .ipv_sof     (ipv_sof),
    .frame_valid (frame_valid),
    .fifo_level  (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vv;
    logic [3:0] vin;
    logic       out;
    logic       sof;
    logic       fv;
    logic       rdy;
    logic [1:0] lvl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic vv, input logic [3:0] v,
                     input logic o, input logic s, input logic f,
                     input logic rd, input logic [1:0] l);
    vec_t e;
    e.rst = r; e.vv = vv; e.vin = v;
    e.out = o; e.sof = s; e.fv = f; e.rdy = rd; e.lvl = l;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_q[$];
    logic [3:0] rx_q[$];
    logic [3:0] word;
    int         idx;
    int         pushed;
    logic       taken;

    rst = 1'b1; vin = '0; vin_valid = 1'b0;

    // ---- per-cycle expectations after each rising edge (rst vv vin | out sof fv rdy lvl) ----
    // Reset, then three idle frames: sof every 4 cycles.
    add(1,0,4'h0, 0,1,0,1,0);                                   // 0
    for (int i = 1; i < 12; i++)
      add(0,0,4'h0, 0,(i % 4 == 0),0,1,0);                      // 1..11
    add(0,0,4'h0, 0,1,0,1,0);                                   // 12
    // Single vector 1011 pushed mid-frame, sent next frame as 1,1,0,1, then idle.
    add(0,1,4'hB, 0,0,0,1,1);                                   // 13
    add(0,0,4'h0, 0,0,0,1,1);                                   // 14
    add(0,0,4'h0, 0,0,0,1,1);                                   // 15
    add(0,0,4'h0, 1,1,1,1,0);                                   // 16
    add(0,0,4'h0, 1,0,1,1,0);                                   // 17
    add(0,0,4'h0, 0,0,1,1,0);                                   // 18
    add(0,0,4'h0, 1,0,1,1,0);                                   // 19
    add(0,0,4'h0, 0,1,0,1,0);                                   // 20
    for (int i = 21; i < 24; i++) add(0,0,4'h0, 0,0,0,1,0);     // 21..23
    // Back-to-back A,5,F,0 with valid held; F and 0 wait for ready.
    add(0,1,4'hA, 0,1,0,1,1);                                   // 24 push on idle boundary
    add(0,1,4'h5, 0,0,0,0,2);                                   // 25 full
    add(0,1,4'hF, 0,0,0,0,2);                                   // 26
    add(0,1,4'hF, 0,0,0,0,2);                                   // 27
    add(0,1,4'hF, 0,1,1,1,1);                                   // 28 pop A
    add(0,1,4'hF, 1,0,1,0,2);                                   // 29 push F
    add(0,1,4'h0, 0,0,1,0,2);                                   // 30
    add(0,1,4'h0, 1,0,1,0,2);                                   // 31
    add(0,1,4'h0, 1,1,1,1,1);                                   // 32 pop 5
    add(0,1,4'h0, 0,0,1,0,2);                                   // 33 push 0
    add(0,0,4'h0, 1,0,1,0,2);                                   // 34
    add(0,0,4'h0, 0,0,1,0,2);                                   // 35
    add(0,0,4'h0, 1,1,1,1,1);                                   // 36 pop F
    for (int i = 37; i < 40; i++) add(0,0,4'h0, 1,0,1,1,1);     // 37..39
    add(0,0,4'h0, 0,1,1,1,0);                                   // 40 pop 0
    for (int i = 41; i < 44; i++) add(0,0,4'h0, 0,0,1,1,0);     // 41..43
    add(0,0,4'h0, 0,1,0,1,0);                                   // 44 idle
    // Push on the boundary edge at level 1: same-edge pop, level stays 1, 6 then 9.
    add(0,1,4'h6, 0,0,0,1,1);                                   // 45
    add(0,0,4'h0, 0,0,0,1,1);                                   // 46
    add(0,0,4'h0, 0,0,0,1,1);                                   // 47
    add(0,1,4'h9, 0,1,1,1,1);                                   // 48 push+pop
    add(0,0,4'h0, 1,0,1,1,1);                                   // 49
    add(0,0,4'h0, 1,0,1,1,1);                                   // 50
    add(0,0,4'h0, 0,0,1,1,1);                                   // 51
    add(0,0,4'h0, 1,1,1,1,0);                                   // 52 pop 9
    add(0,0,4'h0, 0,0,1,1,0);                                   // 53
    add(0,0,4'h0, 0,0,1,1,0);                                   // 54
    add(0,0,4'h0, 1,0,1,1,0);                                   // 55
    add(0,0,4'h0, 0,1,0,1,0);                                   // 56 idle
    // Reset mid-frame with two queued: everything dropped, next frames idle.
    add(0,1,4'hC, 0,0,0,1,1);                                   // 57
    add(0,1,4'h3, 0,0,0,0,2);                                   // 58
    add(0,0,4'h0, 0,0,0,0,2);                                   // 59
    add(0,0,4'h0, 0,1,1,1,1);                                   // 60 pop C
    add(0,1,4'h7, 0,0,1,0,2);                                   // 61 push 7
    add(1,0,4'h0, 0,1,0,1,0);                                   // 62 reset
    add(0,0,4'h0, 0,0,0,1,0);                                   // 63
    add(0,0,4'h0, 0,0,0,1,0);                                   // 64
    add(0,0,4'h0, 0,0,0,1,0);                                   // 65
    add(0,0,4'h0, 0,1,0,1,0);                                   // 66 idle
    add(0,0,4'h0, 0,0,0,1,0);                                   // 67

    for (int i = 0; i < tbl.size(); i++) begin
      rst       = tbl[i].rst;
      vin_valid = tbl[i].vv;
      vin       = tbl[i].vin;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("r%0d.ipv_out", i),     32'(ipv_out),     32'(tbl[i].out));
      chk($sformatf("r%0d.ipv_sof", i),     32'(ipv_sof),     32'(tbl[i].sof));
      chk($sformatf("r%0d.frame_valid", i), 32'(frame_valid), 32'(tbl[i].fv));
      chk($sformatf("r%0d.vin_ready", i),   32'(vin_ready),   32'(tbl[i].rdy));
      chk($sformatf("r%0d.fifo_level", i),  32'(fifo_level),  32'(tbl[i].lvl));
    end

    // ---- randomized loopback through a behavioural serial-to-parallel reducer ----
    rst = 1'b1; vin_valid = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    idx    = 0;
    word   = '0;
    pushed = 0;
    taken  = 1'b0;
    for (int cyc = 0; cyc < 8000 && !(pushed == NRAND && rx_q.size() == NRAND); cyc++) begin
      @(negedge clk);
      if (ipv_sof) begin
        idx  = 0;
        word = '0;
      end
      if (frame_valid && idx < K) begin
        word[idx] = ipv_out;
        if (idx == K - 1) rx_q.push_back(word);
      end
      idx++;
      if (!(vin_valid && !taken)) begin
        if (pushed < NRAND && $urandom_range(0, 9) < 6) begin
          vin       = 4'($urandom);
          vin_valid = 1'b1;
        end else begin
          vin_valid = 1'b0;
        end
      end
      taken = vin_valid && vin_ready;
      if (taken) begin
        exp_q.push_back(vin);
        pushed++;
      end
    end
    vin_valid = 1'b0;

    chk("loop.pushed", 32'(pushed), 32'(NRAND));
    chk("loop.received", 32'(rx_q.size()), 32'(NRAND));
    for (int i = 0; i < NRAND; i++) begin
      if (i < rx_q.size() && i < exp_q.size())
        chk($sformatf("loop.v%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
